md_unit: RTL
============

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand and HI/LO register width (8..64).
REQ-002 SHALL have parameter MUL_LAT, default 5, meaning cycles from multiply issue edge to HI/LO commit edge (>=1).
REQ-003 SHALL have parameter DIV_LAT, default 10, meaning cycles from divide issue edge to HI/LO commit edge (>=1).
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port rs, input, WIDTH, first operand / mthi-mtlo source.
REQ-007 SHALL have port rt, input, WIDTH, second operand.
REQ-008 SHALL have port op, input, 4, operation code from the shared package.
REQ-009 SHALL have port req, input, 1, exception request: suppresses issue of the op presented this cycle.
REQ-010 SHALL have port busy, output, 1, unit occupied or starting this cycle.
REQ-011 SHALL have port hl_res, output, WIDTH, mfhi/mflo read data.
REQ-012 SHALL have port div_zero, output, 1, one-cycle pulse on divide-by-zero commit.

Function
REQ-013 SHALL use a 3-state FSM: IDLE, MUL, DIV; a down-counter loads MUL_LAT or DIV_LAT on issue.
REQ-014 SHALL issue in IDLE when req=0 and op in {mult, multu, div, divu, madd, maddu, msub, msubu}: operands latched, go to MUL/DIV.
REQ-015 SHALL commit HI/LO on the edge where counter==1, then return to IDLE; new values readable the following cycle.
REQ-016 SHALL drive busy = (issue-class op && req=0 && IDLE) | (state != IDLE), combinationally.
REQ-017 SHALL ignore every op other than mfhi/mflo while state != IDLE; the in-flight operation completes regardless of req.
REQ-018 SHALL, in IDLE with req=0, write HI<=rs on mthi and LO<=rs on mtlo at the clock edge.
REQ-019 SHALL drive hl_res = HI on mfhi, LO on mflo, else 0, from committed registers only (never in-flight results).
REQ-020 SHALL compute mult/multu as signed/unsigned 2*WIDTH product, {HI,LO} = product.
REQ-021 SHALL compute div/divu as LO=quotient, HI=remainder, truncated toward zero, remainder sign = dividend sign.
REQ-022 SHALL, on signed MIN / -1, commit LO=MIN, HI=0.
REQ-023 SHALL, on divisor 0, leave HI/LO unchanged, still take DIV_LAT cycles, and pulse div_zero in the cycle after commit edge.
REQ-024 SHALL, when req=1 in the issue cycle, perform no write and keep busy=0 from that op.

Reset
REQ-025 SHALL, while reset_n=0, clear HI, LO, counter, div_zero and force state IDLE, independent of clk.
REQ-026 SHALL, on reset mid-operation, discard the in-flight result with no commit.

Configuration
REQ-027 SHALL, with MD_UNIT_MACC_EN defined, support madd/maddu ({HI,LO} += product) and msub/msubu ({HI,LO} -= product), modulo 2^(2*WIDTH), latency MUL_LAT, accumulated against HI/LO values at commit.
REQ-028 SHALL, without MD_UNIT_MACC_EN, treat madd/maddu/msub/msubu as no-ops (busy=0, no state change).

Structure
REQ-029 SHALL place op codes (none=0, mult=1, multu=2, div=3, divu=4, mfhi=5, mflo=6, mthi=7, mtlo=8, madd=9, maddu=10, msub=11, msubu=12) and the FSM state type in shared package md_pkg.
REQ-030 SHALL implement the latency counter (load, decrement, done==1) as sub-module md_lat_ctr.

Verification
REQ-031 SHALL cover: WIDTH=32, mult rs=-3 rt=7 -> busy 6 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-032 SHALL cover: divu rs=100 rt=7 -> busy 11 cycles, LO=14, HI=2; div rs=-7 rt=2 -> LO=-3, HI=-1.
REQ-033 SHALL cover: div rs=5 rt=0 after mthi 0xAA -> HI stays 0xAA, div_zero one-cycle pulse after 11 busy cycles.
REQ-034 SHALL cover: mult issued with req=1 -> busy=0, HI/LO unchanged; mthi during busy -> ignored.
REQ-035 SHALL cover: reset_n low 3 cycles into div -> HI=LO=0, busy=0 immediately, no later commit.
REQ-036 SHALL cover: MD_UNIT_MACC_EN, HI=0 LO=10, madd rs=2 rt=3 -> LO=16; msubu rs=1 rt=20 -> {HI,LO}=-4 (all ones HI).

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM state type
// and the latency-counter width helper.
package md_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10,
        OP_MSUB  = 4'd11,
        OP_MSUBU = 4'd12
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV
    } md_state_e;

    function automatic int lat_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/md_lat_ctr.sv
// Latency down-counter: loads on issue, counts to zero, flags the commit edge.
module md_lat_ctr #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == CW'(1));

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Optional multiply-accumulate ops are enabled by defining MD_UNIT_MACC_EN.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic [3:0]       op,
    input  logic             req,
    output logic             busy,
    output logic [WIDTH-1:0] hl_res,
    output logic             div_zero
);

    localparam int CW = lat_width(MUL_LAT, DIV_LAT);

    md_state_e        state_q, state_d;
    md_op_e           op_q, op_d;
    md_op_e           op_e;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] rs_q, rs_d, rt_q, rt_d;
    logic             div_zero_q, div_zero_d;

    logic mul_iss, div_iss, idle, issue, ctr_done;

    assign op_e = md_op_e'(op);

    always_comb begin
        mul_iss = 1'b0;
        div_iss = 1'b0;
        case (op_e)
            OP_MULT, OP_MULTU: mul_iss = 1'b1;
`ifdef MD_UNIT_MACC_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: mul_iss = 1'b1;
`endif
            OP_DIV, OP_DIVU: div_iss = 1'b1;
            default: ;
        endcase
    end

    assign idle  = (state_q == ST_IDLE);
    assign issue = idle && !req && (mul_iss || div_iss);
    assign busy  = issue || !idle;

    md_lat_ctr #(.CW(CW)) u_ctr (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (issue),
        .load_val (mul_iss ? CW'(MUL_LAT) : CW'(DIV_LAT)),
        .done     (ctr_done)
    );

    // Multiply: a 2W x 2W product of extended operands, truncated, is the exact product.
    logic             mul_sgn;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod, acc;

    always_comb begin
        mul_sgn = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
        a_ext   = mul_sgn ? {{WIDTH{rs_q[WIDTH-1]}}, rs_q} : {{WIDTH{1'b0}}, rs_q};
        b_ext   = mul_sgn ? {{WIDTH{rt_q[WIDTH-1]}}, rt_q} : {{WIDTH{1'b0}}, rt_q};
        prod    = a_ext * b_ext;
        case (op_q)
            OP_MADD, OP_MADDU: acc = {hi_q, lo_q} + prod;
            OP_MSUB, OP_MSUBU: acc = {hi_q, lo_q} - prod;
            default:           acc = prod;
        endcase
    end

    // Divide on magnitudes so MIN / -1 wraps to MIN with remainder 0.
    logic             div_sgn, a_neg, b_neg, div_by0;
    logic [WIDTH-1:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

    always_comb begin
        div_sgn = (op_q == OP_DIV);
        a_neg   = div_sgn && rs_q[WIDTH-1];
        b_neg   = div_sgn && rt_q[WIDTH-1];
        a_mag   = a_neg ? -rs_q : rs_q;
        b_mag   = b_neg ? -rt_q : rt_q;
        div_by0 = (rt_q == '0);
        b_safe  = div_by0 ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
        q_mag   = a_mag / b_safe;
        r_mag   = a_mag % b_safe;
        quo     = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem     = a_neg ? -r_mag : r_mag;
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        div_zero_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    rs_d    = rs;
                    rt_d    = rt;
                    op_d    = op_e;
                    state_d = mul_iss ? ST_MUL : ST_DIV;
                end else if (!req && op_e == OP_MTHI) begin
                    hi_d = rs;
                end else if (!req && op_e == OP_MTLO) begin
                    lo_d = rs;
                end
            end
            ST_MUL: begin
                if (ctr_done) begin
                    {hi_d, lo_d} = acc;
                    state_d      = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (ctr_done) begin
                    state_d = ST_IDLE;
                    if (div_by0) begin
                        div_zero_d = 1'b1;
                    end else begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_NONE;
            hi_q       <= '0;
            lo_q       <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            div_zero_q <= div_zero_d;
        end
    end

    always_comb begin
        case (op_e)
            OP_MFHI: hl_res = hi_q;
            OP_MFLO: hl_res = lo_q;
            default: hl_res = '0;
        endcase
    end

    assign div_zero = div_zero_q;

endmodule
